subleq_core: RTL and testbench
==============================

# subleq_core

Parametrised next-generation SUBLEQ processor core with an internal sequencing FSM, replacing the fixed 64-bit datapath that needs an external state bus. It executes `mem[b] <= mem[b] - mem[a]; if result <= 0 then pc <= c else pc <= pc + 3` over a single variable-latency req/ack memory port. It adds start, halt and address-fault detection, plus an instruction counter. It sits between the top-level testbench/SoC glue and a word-addressed memory of width DATA_W.

## Interface
- DATA_W, 64: word width; operands and data are signed two's complement.
- ADDR_W, 16: memory address width; memory has 2^ADDR_W words.
- RESET_PC, 0: PC loaded on `start`.
- CNT_W, 32: instruction counter width.

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begins execution from RESET_PC; honoured only in IDLE, HALTED or FAULT
- mem_req  out  1  memory request; held until ack
- mem_we  out  1  1 = write, 0 = read; valid while mem_req
- mem_addr  out  ADDR_W  word address; valid while mem_req
- mem_wdata  out  DATA_W  write data; valid while mem_req && mem_we
- mem_rdata  in  DATA_W  read data; sampled on the clk edge where mem_ack=1
- mem_ack  in  1  completes the current request
- running  out  1  FSM is not in IDLE, HALTED or FAULT
- halted  out  1  normal halt reached
- fault  out  1  address fault halt
- pc  out  ADDR_W  current instruction address
- instr_count  out  CNT_W  completed instructions since last start

## Operation
- States: IDLE, RD_A, RD_B, RD_C, RD_MA, RD_MB, EXEC, WR, HALTED, FAULT.
- IDLE/HALTED/FAULT + start: pc <= RESET_PC, instr_count <= 0, halted/fault <= 0, go to RD_A.
- Read states issue the following addresses:
  - RD_A: pc
  - RD_B: pc+1
  - RD_C: pc+2
  - RD_MA: a[ADDR_W-1:0]
  - RD_MB: b[ADDR_W-1:0]
- A read state latches mem_rdata into its register on the ack edge and advances. Without ack, the state holds and the request stays stable.
- Address arithmetic pc+1, pc+2 and pc+3 wraps modulo 2^ADDR_W.
- Fault check applies only when DATA_W > ADDR_W:
  - If operand a has any nonzero bit above ADDR_W-1 on its RD_A ack, go to FAULT. The same rule applies to b at RD_B and c at RD_C.
  - No further memory access occurs after a fault.
  - fault=1 and pc holds the faulting instruction address.
- EXEC (1 cycle, no request): result <= mem_b - mem_a, modulo 2^DATA_W. take <= result[DATA_W-1] | (result == 0).
- WR: write result to b. On ack:
  - instr_count++ (wraps).
  - pc <= take ? c : pc+3.
  - If take && c == pc, go to HALTED (jump-to-self); otherwise go to RD_A.
- mem_req is deasserted in EXEC, IDLE, HALTED and FAULT.
- start asserted while running is ignored.

## Timing
- Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, running=0, halted=0, fault=0, pc=RESET_PC, instr_count=0, state IDLE.
- mem_* outputs are driven from registered state and operands, with no combinational path from mem_ack.
- Zero-wait memory (ack in the first req cycle) gives 7 cycles per instruction: 5 reads + EXEC + WR. Each wait cycle adds 1.
- Start latency: start sampled at edge N gives mem_req=1 with addr=RESET_PC in cycle N+1.
- Reset mid-access drops mem_req asynchronously and discards any in-flight write.

## Structure
- Package subleq_pkg holds:
  - the state enum
  - state encodings
  - the instruction length constant (3)
- Sub-module subleq_alu (parametrised DATA_W subtract) outputs result, zero and negative.
- The FSM, operand registers and pc logic live in subleq_core.

## Test plan
- Zero-wait memory with program at 0: `{a=9,b=10,c=3}`, mem[9]=5, mem[10]=7.
  - Required: mem[10]=2, pc=3, instr_count=1, 7 cycles from the first req.
- mem[9]=7, mem[10]=7, c=0 at pc=0.
  - Required: result 0, branch taken, c==pc, so halted=1 and running=0 after the write ack.
- Random 0-3 cycle ack delays over a 3-instruction negation program.
  - Required: results identical to the zero-wait run; addr and wdata stable while req is held.
- DATA_W=64, ADDR_W=16, operand b=0x1_0000.
  - Required: FAULT after the RD_B ack, fault=1, no further mem_req, pc unchanged.
- Assert rst during WR with ack withheld.
  - Required: mem_req=0 immediately, state IDLE, pc=RESET_PC. A subsequent start re-runs cleanly.
- pc=0xFFFE, ADDR_W=16, branch not taken.
  - Required: operand reads at 0xFFFE, 0xFFFF and 0x0000; next pc=0x0001.

Source files
------------

// File: rtl/subleq_pkg.sv
// Shared types and constants for the SUBLEQ core: FSM state encoding and instruction geometry.
package subleq_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_RD_A   = 4'd1,
        S_RD_B   = 4'd2,
        S_RD_C   = 4'd3,
        S_RD_MA  = 4'd4,
        S_RD_MB  = 4'd5,
        S_EXEC   = 4'd6,
        S_WR     = 4'd7,
        S_HALTED = 4'd8,
        S_FAULT  = 4'd9
    } state_t;

    // Words per instruction (a, b, c); also the fall-through pc increment.
    localparam int INSTR_LEN = 3;

    function automatic logic is_parked(state_t s);
        return (s == S_IDLE) || (s == S_HALTED) || (s == S_FAULT);
    endfunction

endpackage

// File: rtl/subleq_alu.sv
// Two's-complement subtractor for SUBLEQ: result = minuend - subtrahend, with zero/negative flags.
module subleq_alu #(
    parameter int DATA_W = 64
) (
    input  logic signed [DATA_W-1:0] minuend,
    input  logic signed [DATA_W-1:0] subtrahend,
    output logic signed [DATA_W-1:0] result,
    output logic                     zero,
    output logic                     negative
);

    assign result   = minuend - subtrahend;
    assign zero     = (result == '0);
    assign negative = result[DATA_W-1];

endmodule

// File: rtl/subleq_core.sv
// SUBLEQ processor core: fetches a, b, c and both operands over one req/ack port, writes mem[b]-mem[a] back, branches on <= 0.
module subleq_core
    import subleq_pkg::*;
#(
    parameter int          DATA_W   = 64,
    parameter int          ADDR_W   = 16,
    parameter int unsigned RESET_PC = 0,
    parameter int          CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              running,
    output logic              halted,
    output logic              fault,
    output logic [ADDR_W-1:0] pc,
    output logic [CNT_W-1:0]  instr_count
);

    localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(INSTR_LEN);

    state_t state, state_nx;

    logic [ADDR_W-1:0]        op_a, op_b, op_c;
    logic signed [DATA_W-1:0] mem_a, mem_b;
    logic signed [DATA_W-1:0] diff_p1;
    logic                     take_p1;

    logic signed [DATA_W-1:0] alu_result;
    logic                     alu_zero, alu_neg;
    logic                     addr_overflow;
    logic                     jump_to_self;

    subleq_alu #(.DATA_W(DATA_W)) u_alu (
        .minuend    (mem_b),
        .subtrahend (mem_a),
        .result     (alu_result),
        .zero       (alu_zero),
        .negative   (alu_neg)
    );

    // An address operand must fit in ADDR_W bits; upper bits only exist when DATA_W > ADDR_W.
    assign addr_overflow = (DATA_W > ADDR_W) && ((mem_rdata >> ADDR_W) != '0);
    assign jump_to_self  = take_p1 && (op_c == pc);
    assign running       = !is_parked(state);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state)
            S_IDLE, S_HALTED, S_FAULT: begin
                if (start) state_nx = S_RD_A;
            end
            S_RD_A: begin
                mem_req  = 1'b1;
                mem_addr = pc;
                if (mem_ack) state_nx = addr_overflow ? S_FAULT : S_RD_B;
            end
            S_RD_B: begin
                mem_req  = 1'b1;
                mem_addr = pc + ADDR_W'(1);
                if (mem_ack) state_nx = addr_overflow ? S_FAULT : S_RD_C;
            end
            S_RD_C: begin
                mem_req  = 1'b1;
                mem_addr = pc + ADDR_W'(2);
                if (mem_ack) state_nx = addr_overflow ? S_FAULT : S_RD_MA;
            end
            S_RD_MA: begin
                mem_req  = 1'b1;
                mem_addr = op_a;
                if (mem_ack) state_nx = S_RD_MB;
            end
            S_RD_MB: begin
                mem_req  = 1'b1;
                mem_addr = op_b;
                if (mem_ack) state_nx = S_EXEC;
            end
            S_EXEC: begin
                state_nx = S_WR;
            end
            S_WR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = op_b;
                mem_wdata = diff_p1;
                if (mem_ack) state_nx = jump_to_self ? S_HALTED : S_RD_A;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Architectural control state: pc, counter and sticky status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_ADDR;
            instr_count <= '0;
            halted      <= 1'b0;
            fault       <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_HALTED, S_FAULT: begin
                    if (start) begin
                        pc          <= RESET_ADDR;
                        instr_count <= '0;
                        halted      <= 1'b0;
                        fault       <= 1'b0;
                    end
                end
                S_RD_A, S_RD_B, S_RD_C: begin
                    if (mem_ack && addr_overflow) fault <= 1'b1;
                end
                S_WR: begin
                    if (mem_ack) begin
                        instr_count <= instr_count + CNT_W'(1);
                        pc          <= take_p1 ? op_c : pc + STEP;
                        if (jump_to_self) halted <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Operand capture on each read ack.
    always_ff @(posedge clk) begin
        case (state)
            S_RD_A:  if (mem_ack) op_a  <= mem_rdata[ADDR_W-1:0];
            S_RD_B:  if (mem_ack) op_b  <= mem_rdata[ADDR_W-1:0];
            S_RD_C:  if (mem_ack) op_c  <= mem_rdata[ADDR_W-1:0];
            S_RD_MA: if (mem_ack) mem_a <= mem_rdata;
            S_RD_MB: if (mem_ack) mem_b <= mem_rdata;
            default: ;
        endcase
    end

    // EXEC -> WR boundary: difference and branch decision registered for the write-back.
    always_ff @(posedge clk) begin
        if (state == S_EXEC) begin
            diff_p1 <= alu_result;
            take_p1 <= alu_neg | alu_zero;
        end
    end

endmodule

// File: tb/tb_subleq_core.sv
// Randomized scoreboard bench for subleq_core: a SUBLEQ interpreter predicts every memory transaction and final state.
module tb_subleq_core;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 16;
    localparam int CNT_W  = 32;

    logic              clk;
    logic              rst;
    logic              start;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              running;
    logic              halted;
    logic              fault;
    logic [ADDR_W-1:0] pc;
    logic [CNT_W-1:0]  instr_count;

    subleq_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RESET_PC(0), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .running     (running),
        .halted      (halted),
        .fault       (fault),
        .pc          (pc),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } xact_t;

    logic [DATA_W-1:0] mem     [0:65535];
    logic [DATA_W-1:0] ref_mem [0:65535];
    xact_t             exp_q[$];
    xact_t             obs;
    event              ack_ev;

    int n_chk  = 0;
    int n_pass = 0;

    int  max_delay   = 0;
    bit  hold_wr     = 0;
    int  n_acks      = 0;
    int  n_wr        = 0;
    int  last_wr_cyc = 0;

    logic [ADDR_W-1:0] exp_pc;
    int                exp_cnt;
    bit                exp_halt, exp_fault;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Memory responder: random ack latency, stability of held requests, optional withholding of writes.
    initial begin
        int                wcnt;
        int                dly;
        logic [ADDR_W-1:0] lat_addr;
        logic              lat_we;
        logic [DATA_W-1:0] lat_wdata;
        wcnt = 0; dly = 0; lat_addr = '0; lat_we = 1'b0; lat_wdata = '0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (rst || !mem_req) begin
                wcnt = 0;
                continue;
            end
            if (wcnt == 0) begin
                lat_addr  = mem_addr;
                lat_we    = mem_we;
                lat_wdata = mem_wdata;
                dly       = $urandom_range(max_delay, 0);
            end else begin
                chk("held_addr", 64'(mem_addr), 64'(lat_addr));
                chk("held_we", 64'(mem_we), 64'(lat_we));
                if (lat_we) chk("held_wdata", mem_wdata, lat_wdata);
            end
            if (lat_we && hold_wr) begin
                wcnt++;
                continue;
            end
            if (wcnt >= dly) begin
                mem_ack = 1'b1;
                if (mem_we) begin
                    mem[mem_addr] = mem_wdata;
                    n_wr++;
                    last_wr_cyc = cyc;
                    obs = '{we: 1'b1, addr: mem_addr, data: mem_wdata};
                end else begin
                    mem_rdata = mem[mem_addr];
                    obs = '{we: 1'b0, addr: mem_addr, data: mem_rdata};
                end
                n_acks++;
                wcnt = 0;
                -> ack_ev;
            end else begin
                wcnt++;
            end
        end
    end

    // Scoreboard monitor: each completed transaction is matched against the next predicted one.
    initial begin
        xact_t e;
        forever begin
            @(ack_ev);
            if (exp_q.size() == 0) begin
                chk("unexpected_xact_addr", 64'(obs.addr), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("xact_we", 64'(obs.we), 64'(e.we));
                chk("xact_addr", 64'(obs.addr), 64'(e.addr));
                if (e.we) chk("xact_wdata", obs.data, e.data);
            end
        end
    end

    // Reference interpreter over ref_mem: predicts the transaction stream and the final architectural state.
    task automatic model_run();
        logic [ADDR_W-1:0] p, p1, p2, a, b, c;
        logic [DATA_W-1:0] wa, wb, wc, r;
        int n;
        p = '0; n = 0; exp_halt = 0; exp_fault = 0;
        for (int k = 0; k < 200; k++) begin
            p1 = p + 16'd1;
            p2 = p + 16'd2;
            exp_q.push_back('{we: 1'b0, addr: p, data: '0});
            wa = ref_mem[p];
            if (wa[DATA_W-1:ADDR_W] != '0) begin exp_fault = 1; break; end
            exp_q.push_back('{we: 1'b0, addr: p1, data: '0});
            wb = ref_mem[p1];
            if (wb[DATA_W-1:ADDR_W] != '0) begin exp_fault = 1; break; end
            exp_q.push_back('{we: 1'b0, addr: p2, data: '0});
            wc = ref_mem[p2];
            if (wc[DATA_W-1:ADDR_W] != '0) begin exp_fault = 1; break; end
            a = wa[ADDR_W-1:0];
            b = wb[ADDR_W-1:0];
            c = wc[ADDR_W-1:0];
            exp_q.push_back('{we: 1'b0, addr: a, data: '0});
            exp_q.push_back('{we: 1'b0, addr: b, data: '0});
            r = ref_mem[b] - ref_mem[a];
            ref_mem[b] = r;
            exp_q.push_back('{we: 1'b1, addr: b, data: r});
            n++;
            if ($signed(r) <= 0) begin
                if (c == p) begin exp_halt = 1; break; end
                p = c;
            end else begin
                p = p + 16'd3;
            end
        end
        exp_pc  = p;
        exp_cnt = n;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
    endtask

    task automatic put(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] val);
        mem[addr]     = val;
        ref_mem[addr] = val;
    endtask

    task automatic pulse_start(input int delay);
        exp_q.delete();
        model_run();
        n_wr = 0;
        n_acks = 0;
        max_delay = delay;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
    endtask

    task automatic wait_idle(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!running) return;
            @(negedge clk);
            #1;
        end
        chk({name, "_timeout_running"}, 64'(running), 64'd0);
    endtask

    task automatic wait_wr(input string name, input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (n_wr >= n) return;
        end
        chk({name, "_timeout_writes"}, 64'(n_wr), 64'(n));
    endtask

    task automatic check_end(input string name);
        chk({name, "_running"}, 64'(running), 64'd0);
        chk({name, "_halted"}, 64'(halted), 64'(exp_halt));
        chk({name, "_fault"}, 64'(fault), 64'(exp_fault));
        chk({name, "_pc"}, 64'(pc), 64'(exp_pc));
        chk({name, "_count"}, 64'(instr_count), 64'(exp_cnt));
        chk({name, "_pending_xacts"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic load_basic();
        clear_mem();
        put(16'd0, 64'd9);  put(16'd1, 64'd10); put(16'd2, 64'd3);
        put(16'd3, 64'd11); put(16'd4, 64'd11); put(16'd5, 64'd3);
        put(16'd9, 64'd5);  put(16'd10, 64'd7);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
        $fatal(1);
    end

    initial begin
        logic [DATA_W-1:0] x;
        logic [DATA_W-1:0] snap [0:3];
        int cyc0;
        int req_seen;

        start = 1'b0;
        rst   = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", mem_wdata, 64'd0);
        chk("rst_running", 64'(running), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_fault", 64'(fault), 64'd0);
        chk("rst_pc", 64'(pc), 64'd0);
        chk("rst_count", 64'(instr_count), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single subtract with zero-wait memory, then a halt instruction at 3.
        load_basic();
        pulse_start(0);
        chk("start_latency_req", 64'(mem_req), 64'd1);
        chk("start_latency_addr", 64'(mem_addr), 64'd0);
        cyc0 = cyc;
        wait_wr("basic", 1, 100);
        chk("basic_cycles_per_instr", 64'(last_wr_cyc - cyc0 + 1), 64'd7);
        @(negedge clk);
        #1;
        chk("basic_pc_after_1", 64'(pc), 64'd3);
        chk("basic_count_after_1", 64'(instr_count), 64'd1);
        wait_idle("basic", 200);
        check_end("basic");
        chk("basic_mem10", mem[10], 64'd2);

        // Zero result, branch to self.
        clear_mem();
        put(16'd0, 64'd7); put(16'd1, 64'd8); put(16'd2, 64'd0);
        put(16'd7, 64'd7); put(16'd8, 64'd7);
        pulse_start(0);
        wait_idle("selfjmp", 200);
        check_end("selfjmp");
        chk("selfjmp_mem8", mem[8], 64'd0);

        // Negation program with random operands: zero-wait run vs random-latency run.
        for (int it = 0; it < 4; it++) begin
            x = {$urandom, $urandom};
            for (int pass = 0; pass < 2; pass++) begin
                clear_mem();
                put(16'd0, 64'd20); put(16'd1, 64'd21); put(16'd2, 64'd3);
                put(16'd3, 64'd21); put(16'd4, 64'd22); put(16'd5, 64'd6);
                put(16'd6, 64'd23); put(16'd7, 64'd23); put(16'd8, 64'd6);
                put(16'd20, x);
                put(16'd23, {$urandom, $urandom});
                pulse_start(pass == 0 ? 0 : 3);
                wait_idle("neg", 1000);
                check_end("neg");
                chk("neg_minus_x", mem[21], -x);
                chk("neg_copy_x", mem[22], x);
                if (pass == 0) begin
                    for (int k = 0; k < 4; k++) snap[k] = mem[20 + k];
                end else begin
                    for (int k = 0; k < 4; k++) chk("neg_wait_vs_zero_wait", mem[20 + k], snap[k]);
                end
            end
        end

        // Operand b above the address range faults after the RD_B ack.
        clear_mem();
        put(16'd0, 64'd9); put(16'd1, 64'h1_0000); put(16'd2, 64'd3);
        pulse_start($urandom_range(2, 0));
        wait_idle("fault", 200);
        check_end("fault");
        chk("fault_acks", 64'(n_acks), 64'd2);
        req_seen = 0;
        repeat (20) begin
            @(negedge clk);
            #1;
            if (mem_req) req_seen++;
        end
        chk("fault_no_req", 64'(req_seen), 64'd0);
        chk("fault_pc_hold", 64'(pc), 64'd0);

        // Reset while a write is held without ack.
        load_basic();
        hold_wr = 1;
        pulse_start(0);
        req_seen = 0;
        for (int i = 0; i < 100 && req_seen == 0; i++) begin
            @(negedge clk);
            #1;
            if (mem_req && mem_we) req_seen = 1;
        end
        chk("hold_reached_wr", 64'(req_seen), 64'd1);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_req", 64'(mem_req), 64'd0);
        chk("midrst_running", 64'(running), 64'd0);
        chk("midrst_halted", 64'(halted), 64'd0);
        chk("midrst_fault", 64'(fault), 64'd0);
        chk("midrst_pc", 64'(pc), 64'd0);
        chk("midrst_no_write", mem[10], 64'd7);
        @(negedge clk);
        rst = 1'b0;
        hold_wr = 0;
        load_basic();
        pulse_start(1);
        wait_idle("rerun", 300);
        check_end("rerun");
        chk("rerun_mem10", mem[10], 64'd2);

        // Fall-through across the top of the address space.
        clear_mem();
        put(16'd0, 64'd30); put(16'd1, 64'd30); put(16'd2, 64'hFFFE);
        put(16'hFFFE, 64'd31); put(16'hFFFF, 64'd32);
        put(16'd4, 64'd33); put(16'd5, 64'd33); put(16'd6, 64'd4);
        put(16'd31, 64'd3); put(16'd32, 64'd10);
        pulse_start(2);
        wait_wr("wrap", 2, 500);
        @(negedge clk);
        #1;
        chk("wrap_pc_after_2", 64'(pc), 64'd1);
        chk("wrap_mem32", mem[32], 64'd7);
        wait_idle("wrap", 1000);
        check_end("wrap");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
